// File: rtl/tone_gen_pkg.sv
// Shared constants for the multi-channel tone generator: register offsets,
// STAT bit positions and the default duration prescaler.
package tone_gen_pkg;

    // Per-channel word offsets within the {channel, reg} address
    localparam int unsigned REG_HALF  = 0;
    localparam int unsigned REG_DUR   = 1;
    localparam int unsigned REG_STAT  = 2;
    localparam int unsigned REG_IRQEN = 3;

    // STAT register bit positions
    localparam int unsigned ACTIVE = 0;
    localparam int unsigned DONE   = 1;
    localparam int unsigned STOP   = 2;

    // clk_125mhz cycles per 1 ms duration tick
    localparam int unsigned TICK_DIV_DEFAULT = 125000;

endpackage

// File: rtl/tone_channel.sv
// One tone channel: half-period, remaining duration, phase counter, active,
// sticky done, irq enable and the registered square-wave output.
module tone_channel
    import tone_gen_pkg::*;
#(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned DUR_W = 16
) (
    input  logic             clk_125mhz,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             wr_half_i,
    input  logic             wr_dur_i,
    input  logic             wr_stat_i,
    input  logic             wr_irqen_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] half_o,
    output logic [DUR_W-1:0] remaining_o,
    output logic             active_o,
    output logic             done_o,
    output logic             irq_en_o,
    output logic             tone_o
);

    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             irq_en_q, irq_en_d;
    logic             tone_q, tone_d;
    logic             expire;
    logic             unused_wdata;

    // Only the low bits of the bus word reach any register
    assign unused_wdata = ^wdata_i;

    // Next state: phase/duration first, then bus actions; start overrides all
    always_comb begin
        half_d   = half_q;
        phase_d  = phase_q;
        rem_d    = rem_q;
        active_d = active_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;
        tone_d   = tone_q;
        expire   = 1'b0;

        if (active_q) begin
            if (half_q == '0) begin
                phase_d = '0;
                tone_d  = 1'b0;
            end else if (phase_q >= half_q - CNT_W'(1)) begin
                // >= so that a shrunk HALF wraps at once instead of running away
                phase_d = '0;
                tone_d  = ~tone_q;
            end else begin
                phase_d = phase_q + CNT_W'(1);
            end
            // remaining == 0 means play forever
            if (tick_i && (rem_q != '0)) begin
                if (rem_q == DUR_W'(1)) begin
                    expire = 1'b1;
                end else begin
                    rem_d = rem_q - DUR_W'(1);
                end
            end
        end

        if (expire) begin
            active_d = 1'b0;
            done_d   = 1'b1;
            tone_d   = 1'b0;
            phase_d  = '0;
        end else if (wr_stat_i && wdata_i[DONE]) begin
            done_d = 1'b0;
        end

        if (wr_stat_i && wdata_i[STOP]) begin
            active_d = 1'b0;
            tone_d   = 1'b0;
            phase_d  = '0;
        end

        if (wr_half_i) begin
            half_d = wdata_i[CNT_W-1:0];
        end
        if (wr_irqen_i) begin
            irq_en_d = wdata_i[0];
        end

        // A start beats a same-cycle expiry, so done keeps its old value
        if (wr_dur_i) begin
            active_d = 1'b1;
            phase_d  = '0;
            tone_d   = 1'b0;
            rem_d    = wdata_i[DUR_W-1:0];
            done_d   = done_q;
        end
    end

    // Channel state registers
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            half_q   <= '0;
            phase_q  <= '0;
            rem_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            tone_q   <= 1'b0;
        end else begin
            half_q   <= half_d;
            phase_q  <= phase_d;
            rem_q    <= rem_d;
            active_q <= active_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            tone_q   <= tone_d;
        end
    end

    assign half_o      = half_q;
    assign remaining_o = rem_q;
    assign active_o    = active_q;
    assign done_o      = done_q;
    assign irq_en_o    = irq_en_q;
    assign tone_o      = tone_q;

endmodule

// File: rtl/tone_gen_multi.sv
// Multi-channel memory-mapped square-wave tone generator: shared 1 ms
// prescaler, bus decode, read mux, tone mix and registered interrupt.
module tone_gen_multi
    import tone_gen_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned DUR_W    = 16,
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                   clk_125mhz,
    input  logic                   reset,
    input  logic                   cs,
    input  logic                   we,
    input  logic [$clog2(NCH)+1:0] addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic [NCH-1:0]         tone,
    output logic                   mix,
    output logic                   irq
);

    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic             irq_q, irq_d;
    logic [CH_W-1:0]  ch_sel;
    logic [1:0]       reg_sel;
    logic             ch_valid;
    logic             wr_en;

    logic [CNT_W-1:0] half_a [NCH];
    logic [DUR_W-1:0] rem_a  [NCH];
    logic [NCH-1:0]   active_v;
    logic [NCH-1:0]   done_v;
    logic [NCH-1:0]   ien_v;

    // Address split: upper bits pick the channel, low two bits the register
    if (NCH > 1) begin : g_ch_idx
        assign ch_sel = addr[$clog2(NCH)+1:2];
    end else begin : g_ch_one
        assign ch_sel = '0;
    end
    assign reg_sel  = addr[1:0];
    assign ch_valid = (32'(ch_sel) < 32'(NCH));
    assign wr_en    = cs & we & ch_valid;

    // Free-running prescaler; tick in the cycle it sits at TICK_DIV-1
    assign tick = (presc_q == PW'(TICK_DIV - 1));
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Interrupt follows done & enable one cycle late
    always_comb begin
        irq_d = |(done_v & ien_v);
    end

    // Prescaler and interrupt registers
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            irq_q   <= irq_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic sel;
        assign sel = wr_en && (ch_sel == CH_W'(i));

        tone_channel #(
            .CNT_W (CNT_W),
            .DUR_W (DUR_W)
        ) u_ch (
            .clk_125mhz  (clk_125mhz),
            .reset       (reset),
            .tick_i      (tick),
            .wr_half_i   (sel && (reg_sel == 2'(REG_HALF))),
            .wr_dur_i    (sel && (reg_sel == 2'(REG_DUR))),
            .wr_stat_i   (sel && (reg_sel == 2'(REG_STAT))),
            .wr_irqen_i  (sel && (reg_sel == 2'(REG_IRQEN))),
            .wdata_i     (wdata),
            .half_o      (half_a[i]),
            .remaining_o (rem_a[i]),
            .active_o    (active_v[i]),
            .done_o      (done_v[i]),
            .irq_en_o    (ien_v[i]),
            .tone_o      (tone[i])
        );
    end

    // Read mux; unused bits and out-of-range channels read 0
    always_comb begin
        rdata = '0;
        if (ch_valid) begin
            case (reg_sel)
                2'(REG_HALF):  rdata[CNT_W-1:0] = half_a[ch_sel];
                2'(REG_DUR):   rdata[DUR_W-1:0] = rem_a[ch_sel];
                2'(REG_STAT): begin
                    rdata[ACTIVE] = active_v[ch_sel];
                    rdata[DONE]   = done_v[ch_sel];
                end
                default:       rdata[0] = ien_v[ch_sel];
            endcase
        end
    end

    assign mix = |tone;
    assign irq = irq_q;

endmodule
